// File: rtl/tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tone_sequencer
//  Description : Song-RAM driven multi-voice square-wave tone player with a
//                first-order sigma-delta mixer for a single sound pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module tone_sequencer #(
  parameter int TICKS_PER_MILLI = 100,
  parameter int NUM_VOICES      = 2,
  parameter int DIV_W           = 12,
  parameter int SONG_DEPTH      = 16,
  localparam int ADDR_W         = $clog2(SONG_DEPTH),
  localparam int DATA_W         = NUM_VOICES * DIV_W + 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ready,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_VOICES-1:0] voice_out,
  output logic                  sound,
  output logic [7:0]            led
);

  localparam int MS_W  = $clog2(TICKS_PER_MILLI);
  localparam int ACC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic                    wrap_q, wrap_d;
  logic [ADDR_W-1:0]       led_q, led_d;
  logic [MS_W-1:0]         ms_q, ms_d;
  logic [7:0]              dur_q, dur_d;
  logic [DIV_W-1:0]        hp_q   [NUM_VOICES];
  logic [DIV_W-1:0]        hp_d   [NUM_VOICES];
  logic [DIV_W-1:0]        vcnt_q [NUM_VOICES];
  logic [DIV_W-1:0]        vcnt_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]   vout_q, vout_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    sound_q, sound_d;

  logic [DATA_W-1:0]       mem [SONG_DEPTH];
  logic [DATA_W-1:0]       w_entry;
  logic [ACC_W-1:0]        w_pop;
  logic [ACC_W-1:0]        w_sum;

  assign w_entry   = mem[idx_q];
  assign wr_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign voice_out = vout_q;
  assign sound     = sound_q;
  assign led       = 8'(led_q);

  // Song RAM: writable only while idle, never reset
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == S_IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next-state, counter, voice and mixer logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wrap_d  = wrap_q;
    led_d   = led_q;
    ms_d    = ms_q;
    dur_d   = dur_q;
    hp_d    = hp_q;
    vcnt_d  = vcnt_q;
    vout_d  = vout_q;
    acc_d   = acc_q;
    sound_d = sound_q;
    w_pop   = '0;
    w_sum   = '0;

    case (state_q)
      S_IDLE: begin
        vout_d = '0;
        if (start) begin
          state_d = S_FETCH;
          idx_d   = '0;
          wrap_d  = 1'b0;
        end
      end
      S_FETCH: begin
        vout_d = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
          vcnt_d[v] = '0;
        end
        // A zero duration marks the end of the song, as does running off the RAM
        if ((w_entry[7:0] == 8'd0) || wrap_q) begin
          if (loop_en) begin
            state_d = S_FETCH;
            idx_d   = '0;
            wrap_d  = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            hp_d[v] = w_entry[8 + v*DIV_W +: DIV_W];
          end
          dur_d   = w_entry[7:0];
          ms_d    = '0;
          led_d   = idx_q;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (hp_q[v] == '0) begin
            vout_d[v] = 1'b0;
            vcnt_d[v] = '0;
          end else if (vcnt_q[v] == hp_q[v] - DIV_W'(1)) begin
            vout_d[v] = ~vout_q[v];
            vcnt_d[v] = '0;
          end else begin
            vcnt_d[v] = vcnt_q[v] + DIV_W'(1);
          end
        end
        if (ms_q == MS_W'(TICKS_PER_MILLI - 1)) begin
          ms_d  = '0;
          dur_d = dur_q - 8'd1;
          if (dur_q == 8'd1) begin
            state_d = S_FETCH;
            idx_d   = idx_q + ADDR_W'(1);
            wrap_d  = (idx_q == ADDR_W'(SONG_DEPTH - 1));
          end
        end else begin
          ms_d = ms_q + MS_W'(1);
        end
      end
      S_DONE: begin
        vout_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every other transition while a song is running
    if (stop && ((state_q == S_FETCH) || (state_q == S_PLAY))) begin
      state_d = S_IDLE;
      vout_d  = '0;
    end

    // Sigma-delta: density of sound highs tracks the fraction of active voices
    for (int v = 0; v < NUM_VOICES; v++) begin
      w_pop = w_pop + ACC_W'(vout_q[v]);
    end
    w_sum = acc_q + w_pop;
    if (state_d == S_IDLE) begin
      acc_d   = '0;
      sound_d = 1'b0;
    end else if (w_sum >= ACC_W'(NUM_VOICES)) begin
      acc_d   = w_sum - ACC_W'(NUM_VOICES);
      sound_d = 1'b1;
    end else begin
      acc_d   = w_sum;
      sound_d = 1'b0;
    end
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      led_q   <= '0;
      ms_q    <= '0;
      dur_q   <= '0;
      vout_q  <= '0;
      acc_q   <= '0;
      sound_q <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        hp_q[v]   <= '0;
        vcnt_q[v] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      led_q   <= led_d;
      ms_q    <= ms_d;
      dur_q   <= dur_d;
      vout_q  <= vout_d;
      acc_q   <= acc_d;
      sound_q <= sound_d;
      hp_q    <= hp_d;
      vcnt_q  <= vcnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tone_sequencer
//  Description : Scoreboard bench for tone_sequencer (4 ticks/ms, 2 voices,
//                8-bit half-periods, 8-entry song RAM).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_sequencer;

  localparam int T     = 4;
  localparam int NV    = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int DATAW = NV * DW + 8;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             wr_en   = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DATAW-1:0] wr_data = '0;
  logic             start   = 1'b0;
  logic             stop    = 1'b0;
  logic             loop_en = 1'b0;
  logic             wr_ready, busy, done, sound;
  logic [NV-1:0]    voice_out;
  logic [7:0]       led;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       busy;
    logic       done;
    logic [1:0] voice;
    logic       sound;
    logic [7:0] led;
  } exp_t;

  exp_t sb[$];
  int   m_dur [DEPTH];
  int   m_h0  [DEPTH];
  int   m_h1  [DEPTH];
  int   g_acc;
  logic g_snd;
  int   cur_led = 0;

  tone_sequencer #(
    .TICKS_PER_MILLI(T),
    .NUM_VOICES     (NV),
    .DIV_W          (DW),
    .SONG_DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .busy     (busy),
    .done     (done),
    .voice_out(voice_out),
    .sound    (sound),
    .led      (led)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Square wave of half-period h sampled p cycles into PLAY
  function automatic logic [1:0] voices(input int i, input int p);
    logic [1:0] r;
    r[0] = (m_h0[i] != 0) && (((p / m_h0[i]) % 2) == 1);
    r[1] = (m_h1[i] != 0) && (((p / m_h1[i]) % 2) == 1);
    return r;
  endfunction

  // Push one expected cycle; sound lags the voices by one cycle
  task automatic push_item(input logic b, input logic d, input logic [1:0] v, input int l);
    exp_t e;
    e.busy  = b;
    e.done  = d;
    e.voice = v;
    e.sound = g_snd;
    e.led   = 8'(l);
    sb.push_back(e);
    g_acc = g_acc + int'(v[0]) + int'(v[1]);
    if (g_acc >= NV) begin
      g_snd = 1'b1;
      g_acc = g_acc - NV;
    end else begin
      g_snd = 1'b0;
    end
  endtask

  // Expected cycle-by-cycle trace of one playback starting at entry 0
  task automatic build_trace(input bit lp, input int max_items);
    int         idx;
    bit         wrapped;
    logic [1:0] vf;
    int         l;
    int         dur;
    idx = 0; wrapped = 0; vf = 2'b00; l = cur_led;
    g_acc = 0; g_snd = 1'b0;
    sb.delete();
    while (sb.size() < max_items) begin
      push_item(1'b1, 1'b0, vf, l);
      dur = m_dur[idx];
      if (dur == 0 || wrapped) begin
        vf = 2'b00;
        if (lp) begin
          idx = 0;
          wrapped = 0;
        end else begin
          push_item(1'b1, 1'b1, 2'b00, l);
          push_item(1'b0, 1'b0, 2'b00, l);
          break;
        end
      end else begin
        l = idx;
        for (int p = 0; p < dur * T; p++) begin
          push_item(1'b1, 1'b0, voices(idx, p), l);
        end
        vf = voices(idx, dur * T);
        if (idx == DEPTH - 1) wrapped = 1;
        idx = (idx + 1) % DEPTH;
      end
    end
  endtask

  task automatic write_entry(input int a, input int h1, input int h0, input int d);
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_ready_idle: got %b expected 1", wr_ready);
    end
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = {8'(h1), 8'(h0), 8'(d)};
    m_h1[a] = h1; m_h0[a] = h0; m_dur[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Pulse start and compare ncmp queued cycles (all when ncmp <= 0)
  task automatic run_trace(input bit lp, input bit junk, input int ncmp);
    exp_t e;
    int   n;
    loop_en = lp;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = (ncmp > 0 && ncmp < sb.size()) ? ncmp : sb.size();
    for (int c = 0; c < n; c++) begin
      if (c > 0) @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (busy !== e.busy) begin
        errors++;
        $display("FAIL busy cyc%0d: got %b expected %b", c, busy, e.busy);
      end
      checks++;
      if (done !== e.done) begin
        errors++;
        $display("FAIL done cyc%0d: got %b expected %b", c, done, e.done);
      end
      checks++;
      if (voice_out !== e.voice) begin
        errors++;
        $display("FAIL voice_out cyc%0d: got %b expected %b", c, voice_out, e.voice);
      end
      checks++;
      if (sound !== e.sound) begin
        errors++;
        $display("FAIL sound cyc%0d: got %b expected %b", c, sound, e.sound);
      end
      checks++;
      if (led !== e.led) begin
        errors++;
        $display("FAIL led cyc%0d: got %0d expected %0d", c, led, e.led);
      end
      checks++;
      if (wr_ready !== !e.busy) begin
        errors++;
        $display("FAIL wr_ready cyc%0d: got %b expected %b", c, wr_ready, !e.busy);
      end
      cur_led = int'(e.led);
      wr_en   = junk & e.busy;
      wr_addr = '0;
      wr_data = {8'd1, 8'd1, 8'd7};
    end
    wr_en = 1'b0;
    sb.delete();
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || voice_out !== 2'b00 || sound !== 1'b0) begin
        errors++;
        $display("FAIL %s cyc%0d: got busy=%b done=%b voice=%b sound=%b expected all 0",
                 tag, c, busy, done, voice_out, sound);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || voice_out !== 2'b00 || sound !== 1'b0 ||
        led !== 8'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b voice=%b sound=%b led=%0d wr_ready=%b expected 0/0/00/0/0/1",
               busy, done, voice_out, sound, led, wr_ready);
    end
    rst_n = 1'b1;
    cur_led = 0;
  endtask

  task automatic test_single_song();
    write_entry(0, 0, 3, 2);
    write_entry(1, 0, 0, 0);
    build_trace(1'b0, 1000);
    run_trace(1'b0, 1'b0, 0);
  endtask

  task automatic test_loop_stop();
    build_trace(1'b1, 40);
    run_trace(1'b1, 1'b0, 25);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || voice_out !== 2'b00 || sound !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL stop_abort: got busy=%b voice=%b sound=%b done=%b expected 0/00/0/0",
               busy, voice_out, sound, done);
    end
    check_quiet("after_stop", 4);
    loop_en = 1'b0;
  endtask

  task automatic test_mix();
    write_entry(0, 2, 2, 2);
    write_entry(1, 4, 2, 3);
    write_entry(2, 0, 0, 0);
    build_trace(1'b0, 1000);
    run_trace(1'b0, 1'b0, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DEPTH; i++) begin
      write_entry(i, (i % 2 == 0) ? 0 : i, (i % 3) + 1, 1);
    end
    build_trace(1'b0, 1000);
    run_trace(1'b0, 1'b0, 0);
    @(negedge clk);
    checks++;
    if (led !== 8'd7) begin
      errors++;
      $display("FAIL led_hold_idle: got %0d expected 7", led);
    end
    build_trace(1'b1, 60);
    run_trace(1'b1, 1'b0, 55);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_en = 1'b0;
    check_quiet("wrap_stop", 3);
  endtask

  task automatic test_write_blocked();
    write_entry(0, 0, 3, 2);
    write_entry(1, 0, 0, 0);
    build_trace(1'b0, 1000);
    run_trace(1'b0, 1'b1, 0);
    build_trace(1'b0, 1000);
    run_trace(1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_play();
    build_trace(1'b0, 1000);
    run_trace(1'b0, 1'b0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || voice_out !== 2'b00 || sound !== 1'b0 ||
        led !== 8'd0 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b voice=%b sound=%b led=%0d wr_ready=%b expected 0/0/00/0/0/1",
               busy, done, voice_out, sound, led, wr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_led = 0;
    check_quiet("post_reset", 4);
    build_trace(1'b0, 1000);
    run_trace(1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_single_song();
    test_loop_stop();
    test_mix();
    test_wrap();
    test_write_blocked();
    test_reset_mid_play();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 SHALL have parameter TICKS_PER_MILLI, default 100: clk cycles per millisecond, legal range 2..65535.
REQ-002 SHALL have parameter NUM_VOICES, default 2: simultaneous square-wave voices, legal range 1..4.
REQ-003 SHALL have parameter DIV_W, default 12: width of each voice half-period field.
REQ-004 SHALL have parameter SONG_DEPTH, default 16: song RAM entries, power of two, at least 2; ADDR_W = clog2(SONG_DEPTH).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port wr_en, input, 1 bit: song RAM write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W bits: song RAM write address.
REQ-009 SHALL have port wr_data, input, NUM_VOICES*DIV_W+8 bits: entry data; [7:0] = duration in ms; bits [8+v*DIV_W +: DIV_W] = half-period of voice v.
REQ-010 SHALL have port wr_ready, output, 1 bit: high when writes are accepted.
REQ-011 SHALL have port start, input, 1 bit: begin playback at entry 0.
REQ-012 SHALL have port stop, input, 1 bit: abort playback.
REQ-013 SHALL have port loop_en, input, 1 bit: wrap to entry 0 instead of finishing.
REQ-014 SHALL have port busy, output, 1 bit: high when not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse on normal song completion.
REQ-016 SHALL have port voice_out, output, NUM_VOICES bits: per-voice square waves.
REQ-017 SHALL have port sound, output, 1 bit: mixed voice output.
REQ-018 SHALL have port led, output, 8 bits: current entry index, zero-extended or truncated to 8 bits.

Function
REQ-019 SHALL implement the states IDLE, FETCH, PLAY and DONE.
REQ-020 SHALL drive wr_ready = 1 only in IDLE; a write when wr_en=1 and wr_ready=1 SHALL update the entry at the next edge; writes in any other state SHALL be ignored.
REQ-021 In IDLE, start=1 SHALL move to FETCH with index=0; start in other states SHALL be ignored.
REQ-022 In FETCH (one cycle), if the entry duration is 0 (end marker) or the index passed SONG_DEPTH-1 on the last advance, the block SHALL go to FETCH at index 0 if loop_en=1, else to DONE.
REQ-023 In FETCH with a nonzero duration, the block SHALL latch the half-periods, load dur_cnt=duration, clear ms_cnt and the voice counters, drive voice_out low, and go to PLAY.
REQ-024 In PLAY, ms_cnt SHALL increment each cycle and wrap at TICKS_PER_MILLI-1, decrementing dur_cnt on wrap; on the wrap with dur_cnt=1, the index SHALL increment (wrapping to 0) and the next state SHALL be FETCH.
REQ-025 Each entry SHALL therefore occupy exactly 1 + duration*TICKS_PER_MILLI cycles.
REQ-026 In PLAY, a voice with half-period h>0 SHALL count PLAY cycles and toggle voice_out[v] when its count reaches h-1 (count then 0), giving a period of 2h cycles.
REQ-027 A voice with h=0 (rest) SHALL hold voice_out[v]=0.
REQ-028 The sound output SHALL be a first-order sigma-delta: each cycle acc += popcount(voice_out); if acc >= NUM_VOICES then sound=1 and acc -= NUM_VOICES, else sound=0; acc SHALL clear in IDLE.
REQ-029 When NUM_VOICES=1, sound SHALL equal voice_out[0] delayed by one cycle.
REQ-030 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-031 stop=1 in FETCH or PLAY SHALL go to IDLE at the next edge, with voice_out=0, sound=0, and no done pulse; stop SHALL have priority over all other transitions, and stop in IDLE SHALL be a no-op.
REQ-032 In IDLE, led SHALL hold the last played index.
REQ-033 loop_en SHALL be sampled only in FETCH.

Reset
REQ-034 rst_n=0 SHALL immediately force IDLE, index=0, led=0, busy=0, done=0, voice_out=0, sound=0, all counters and acc=0, and wr_ready=1.
REQ-035 Song RAM contents SHALL NOT be reset and are undefined until written.
REQ-036 Reset asserted mid-playback SHALL abort with no done pulse.

Verification (TICKS_PER_MILLI=4, NUM_VOICES=2, DIV_W=8, SONG_DEPTH=8)
REQ-037 Load entry 0 = {v1=0, v0=3, dur=2} and entry 1 = dur 0, then pulse start -> voice_out[0] toggles every 3 PLAY cycles, voice_out[1]=0, PLAY lasts 8 cycles, done pulses one cycle after the end-marker FETCH, busy falls.
REQ-038 Same song with loop_en=1 -> no done pulse, index returns to 0, busy stays 1; then pulse stop -> IDLE next edge, outputs 0.
REQ-039 Both voices half-period 2 and in phase -> sound equals 1 whenever both voice_out bits are 1 (one-cycle lag), and sound toggles when exactly one voice is high.
REQ-040 All 8 entries with dur=1 -> index wraps 7->0 with loop_en=1, or done pulses after entry 7 with loop_en=0; led tracks 0..7.
REQ-041 wr_en during PLAY with a different wr_data -> RAM unchanged (read back on the next play), wr_ready=0 throughout.
REQ-042 rst_n low for 1 cycle mid-PLAY -> all outputs 0 asynchronously, no done pulse, and a subsequent start replays from entry 0.
